jac_uart: RTL
=============

// Module: jac_uart
// PURPOSE
//  Memory-mapped UART peripheral for the jacaranda-8 computer top level. It sits directly downstream of the
//  computer's I/O decode: it consumes the tx_en/rx_en/begin_flag/tx_data strobes and returns rx_data,
//  status flags and int_req. It serialises 8N1 frames on tx and deserialises frames from rx.
// PARAMETERS
//  CLKS_PER_BIT  default 868  wb_clk_i cycles per UART bit, >=4 (868 = 100 MHz / 115200 baud).
// PORTS
//  wb_clk_i      in   1  system clock; all logic is on its rising edge
//  wb_rst_n      in   1  asynchronous reset, active-low
//  tx_en         in   1  transmitter enable (bit 0 of address 255)
//  rx_en         in   1  receiver / interrupt enable (bit 1 of address 255)
//  begin_flag    in   1  one-cycle start-transmit pulse (write to address 253)
//  tx_data       in   8  byte to transmit; sampled when begin_flag is accepted
//  access_addr   in   8  CPU data address (rs_data)
//  reg_w_en      in   1  CPU register write-back strobe; combined with access_addr==252 it marks an rx_data read
//  rx            in   1  serial input, asynchronous to wb_clk_i
//  tx            out  1  serial output, idle high
//  rx_data       out  8  last correctly received byte (address 252)
//  busy_flag     out  1  transmitter busy (address 254 bit 0)
//  receive_flag  out  1  unread byte present (address 254 bit 1)
//  int_req       out  1  receive interrupt request to the CPU
// BEHAVIOUR
//  Reset values: tx=1, rx_data=0, busy_flag=0, receive_flag=0, int_req=0, both FSMs in IDLE, all counters 0.
//  Baud timing: each FSM has its own bit counter; a bit lasts exactly CLKS_PER_BIT cycles.
//  TX FSM states: IDLE -> START -> DATA(x8, LSB first) -> [PARITY] -> STOP -> IDLE.
//   - In IDLE, begin_flag=1 with tx_en=1 latches tx_data, and busy_flag=1 from the next cycle.
//     tx drives the start bit (0) from that same next cycle.
//   - begin_flag while busy, or while tx_en=0, is ignored; no queueing.
//   - busy_flag falls in the cycle after the last stop-bit cycle. A frame is therefore 10*CLKS_PER_BIT
//     cycles of busy (11 with parity).
//   - tx_en dropping mid-frame does not abort; the current frame completes.
//  RX path: rx passes through a 2-flop synchroniser (2 cycles of latency), then the RX FSM.
//  RX FSM states: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP -> IDLE.
//   - IDLE: a 1->0 edge on the synchronised rx with rx_en=1 enters START.
//   - START: samples at CLKS_PER_BIT/2. If the line reads 1 (glitch), the FSM returns to IDLE.
//   - DATA/STOP: each bit is sampled at the centre, i.e. every CLKS_PER_BIT cycles after the start-bit
//     sample point.
//   - A stop bit of 0 is a framing error: the byte is discarded and no flags change.
//   - A good byte updates rx_data and sets receive_flag=1 in the same cycle. It also sets int_req=1 in
//     that cycle if rx_en=1.
//   - rx_en dropping mid-frame aborts the frame to IDLE without updating rx_data.
//  Read-clear: access_addr==252 && reg_w_en==1 clears receive_flag and int_req on the next edge.
//  Simultaneous good byte and read-clear in one cycle: the new byte wins, so both flags end up 1.
//  Overrun: a new byte overwrites rx_data. receive_flag stays 1 and no error is reported.
//  Reset asserted mid-frame: both FSMs abort immediately, tx returns to 1 and every flag clears.
// CONFIGURATION
//  JAC_UART_PARITY_EN defined:
//   - TX inserts an even-parity bit after D7.
//   - RX checks the parity bit; a mismatch discards the byte exactly like a framing error.
//  JAC_UART_PARITY_EN undefined: plain 8N1 with no parity state in either FSM.
// STRUCTURE
//  Package jac_uart_pkg holds:
//   - the TX/RX state encodings (IDLE, START, DATA, PARITY, STOP);
//   - the address constants UART_CTRL=255, UART_STAT=254, UART_TXD=253, UART_RXD=252.
//  Sub-module jac_uart_rx contains the synchroniser and RX FSM. The TX FSM, flags and read-clear logic
//  stay in jac_uart.
// TESTING  (CLKS_PER_BIT=8)
//  1. tx_en=1, begin_flag pulse with tx_data=0x5A -> busy high for 80 cycles; tx shows 0,0,1,0,1,1,0,1,0,1
//     at bit centres, then idles high.
//  2. rx_en=1, drive frame 0xC3 on rx -> ~2+80 cycles later rx_data=0xC3, receive_flag=1, int_req=1.
//     Then access_addr=252 with reg_w_en=1 -> both flags 0 on the next cycle.
//  3. rx low pulse of 3 cycles (glitch) -> no flag change, RX FSM back in IDLE; rx_data unchanged.
//  4. Frame 0x81 with stop bit=0 -> discarded, flags stay 0. A following good frame 0x7E is received
//     normally.
//  5. Busy transmitting, second begin_flag with 0xFF -> ignored; exactly one frame appears on tx.
//     Good-byte completion coinciding with read-clear -> receive_flag=1.
//  6. Assert wb_rst_n=0 midway through a TX frame and an RX frame -> tx=1, busy/receive/int_req=0
//     immediately. With JAC_UART_PARITY_EN, frame 0x01 carrying parity=0 -> rejected.

Source files
------------

// File: rtl/jac_uart_pkg.sv
// Shared state encodings, register addresses and helpers for the jacaranda-8 UART.
// Parity support is selected by the JAC_UART_PARITY_EN macro in the RTL files.
package jac_uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  localparam logic [7:0] UART_CTRL = 8'd255;
  localparam logic [7:0] UART_STAT = 8'd254;
  localparam logic [7:0] UART_TXD  = 8'd253;
  localparam logic [7:0] UART_RXD  = 8'd252;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic evenParity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/jac_uart_rx.sv
// UART receiver: 2-flop synchroniser, falling-edge start detect and centre-sampling RX FSM.
// With JAC_UART_PARITY_EN defined an even-parity bit is checked between D7 and the stop bit.
module jac_uart_rx
  import jac_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rstN,
  input  logic       i_rx,
  input  logic       i_rxEn,
  output logic       o_byteValid,
  output logic [7:0] o_byte
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_syncPrev;
  uart_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
`ifdef JAC_UART_PARITY_EN
  logic          r_parityOk;
`endif

  logic w_sample;
  logic w_fallEdge;
  logic w_frameOk;

  // Start bit is checked half a bit in; every later bit one full bit after that.
  always_comb begin
    w_sample = 1'b0;
    if (r_state == ST_START) begin
      w_sample = (r_cnt == HALF);
    end else begin
      w_sample = (r_cnt == LAST);
    end
  end

  assign w_fallEdge = r_syncPrev & ~r_sync2;

`ifdef JAC_UART_PARITY_EN
  assign w_frameOk = r_parityOk;
`else
  assign w_frameOk = 1'b1;
`endif

  assign o_byteValid = (r_state == ST_STOP) && w_sample && r_sync2 && i_rxEn && w_frameOk;
  assign o_byte      = r_shift;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_syncPrev <= 1'b1;
    end else begin
      r_sync1    <= i_rx;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
`ifdef JAC_UART_PARITY_EN
      r_parityOk <= 1'b0;
`endif
    end else if ((r_state != ST_IDLE) && !i_rxEn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt    <= '0;
      r_bitIdx <= '0;
      if (i_rxEn && w_fallEdge) begin
        r_state <= ST_START;
      end
    end else begin
      if (w_sample) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_sample) begin
        case (r_state)
          ST_START: begin
            if (r_sync2) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            r_shift  <= {r_sync2, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 3'd1;
            if (r_bitIdx == 3'd7) begin
`ifdef JAC_UART_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end
`ifdef JAC_UART_PARITY_EN
          ST_PARITY: begin
            r_parityOk <= (r_sync2 == evenParity(r_shift));
            r_state    <= ST_STOP;
          end
`endif
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/jac_uart.sv
// Memory-mapped 8N1 UART for jacaranda-8: TX FSM, status flags, read-clear and the RX sub-module.
// Defining JAC_UART_PARITY_EN adds an even-parity bit to both directions.
module jac_uart
  import jac_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n,
  input  logic       tx_en,
  input  logic       rx_en,
  input  logic       begin_flag,
  input  logic [7:0] tx_data,
  input  logic [7:0] access_addr,
  input  logic       reg_w_en,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       busy_flag,
  output logic       receive_flag,
  output logic       int_req
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   r_txState;
  logic [CW-1:0] r_txCnt;
  logic [2:0]    r_txBitIdx;
  logic [7:0]    r_txShift;
  logic          r_tx;
`ifdef JAC_UART_PARITY_EN
  logic          r_txParity;
`endif
  logic [7:0]    r_rxData;
  logic          r_receiveFlag;
  logic          r_intReq;

  logic       w_txBitDone;
  logic       w_readClear;
  logic       w_rxValid;
  logic [7:0] w_rxByte;

  assign w_txBitDone = (r_txCnt == LAST);
  assign w_readClear = reg_w_en && (access_addr == UART_RXD);

  // tx is registered so the line level changes exactly on bit boundaries.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_txState  <= ST_IDLE;
      r_txCnt    <= '0;
      r_txBitIdx <= '0;
      r_txShift  <= '0;
      r_tx       <= 1'b1;
`ifdef JAC_UART_PARITY_EN
      r_txParity <= 1'b0;
`endif
    end else if (r_txState == ST_IDLE) begin
      r_txCnt <= '0;
      if (begin_flag && tx_en) begin
        r_txShift  <= tx_data;
        r_txBitIdx <= '0;
        r_tx       <= 1'b0;
        r_txState  <= ST_START;
`ifdef JAC_UART_PARITY_EN
        r_txParity <= evenParity(tx_data);
`endif
      end
    end else begin
      if (w_txBitDone) begin
        r_txCnt <= '0;
      end else begin
        r_txCnt <= r_txCnt + 1'b1;
      end
      if (w_txBitDone) begin
        case (r_txState)
          ST_START: begin
            r_tx      <= r_txShift[0];
            r_txState <= ST_DATA;
          end
          ST_DATA: begin
            r_txShift  <= r_txShift >> 1;
            r_txBitIdx <= r_txBitIdx + 3'd1;
            if (r_txBitIdx == 3'd7) begin
`ifdef JAC_UART_PARITY_EN
              r_tx      <= r_txParity;
              r_txState <= ST_PARITY;
`else
              r_tx      <= 1'b1;
              r_txState <= ST_STOP;
`endif
            end else begin
              r_tx <= r_txShift[1];
            end
          end
`ifdef JAC_UART_PARITY_EN
          ST_PARITY: begin
            r_tx      <= 1'b1;
            r_txState <= ST_STOP;
          end
`endif
          default: begin
            r_tx      <= 1'b1;
            r_txState <= ST_IDLE;
          end
        endcase
      end
    end
  end

  jac_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk      (wb_clk_i),
    .i_rstN     (wb_rst_n),
    .i_rx       (rx),
    .i_rxEn     (rx_en),
    .o_byteValid(w_rxValid),
    .o_byte     (w_rxByte)
  );

  // A byte landing in the same cycle as a read-clear wins, leaving both flags set.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_rxData      <= '0;
      r_receiveFlag <= 1'b0;
      r_intReq      <= 1'b0;
    end else begin
      if (w_rxValid) begin
        r_rxData      <= w_rxByte;
        r_receiveFlag <= 1'b1;
      end else if (w_readClear) begin
        r_receiveFlag <= 1'b0;
      end
      if (w_rxValid && rx_en) begin
        r_intReq <= 1'b1;
      end else if (w_readClear) begin
        r_intReq <= 1'b0;
      end
    end
  end

  assign tx           = r_tx;
  assign busy_flag    = (r_txState != ST_IDLE);
  assign rx_data      = r_rxData;
  assign receive_flag = r_receiveFlag;
  assign int_req      = r_intReq;

endmodule
